// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT run scheduler.
// Holds the scheduler state enum, the SRAM owner select and size limits.
package fft_pkg;

   localparam int ADDR_W_DEF    = 8;
   localparam int DATA_W_DEF    = 128;
   localparam int MAX_POINT_CFG = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } sched_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_HOST,
      OWN_FFT
   } owner_t;

endpackage

// File: rtl/sram_port_mux.sv
// Combinational SRAM port steering between host and FFT engine.
// Ports: i_owner select, host/FFT address+data+we in, SRAM ports out.
module sram_port_mux
   import fft_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [1:0]        i_owner,
   input  logic              i_host_we,
   input  logic [ADDR_W-1:0] i_host_addr,
   input  logic [DATA_W-1:0] i_host_wdata,
   input  logic [ADDR_W-1:0] i_fft_raddr1,
   input  logic [ADDR_W-1:0] i_fft_raddr2,
   input  logic [ADDR_W-1:0] i_fft_waddr1,
   input  logic [ADDR_W-1:0] i_fft_waddr2,
   input  logic [DATA_W-1:0] i_fft_wdata1,
   input  logic [DATA_W-1:0] i_fft_wdata2,
   input  logic              i_fft_we,
   output logic [ADDR_W-1:0] o_sram_raddr1,
   output logic [ADDR_W-1:0] o_sram_raddr2,
   output logic [ADDR_W-1:0] o_sram_waddr1,
   output logic [ADDR_W-1:0] o_sram_waddr2,
   output logic [DATA_W-1:0] o_sram_wdata1,
   output logic [DATA_W-1:0] o_sram_wdata2,
   output logic              o_sram_we1,
   output logic              o_sram_we2
);

   always_comb begin
      o_sram_raddr1 = '0;
      o_sram_raddr2 = '0;
      o_sram_waddr1 = '0;
      o_sram_waddr2 = '0;
      o_sram_wdata1 = '0;
      o_sram_wdata2 = '0;
      o_sram_we1    = 1'b0;
      o_sram_we2    = 1'b0;
      unique case (1'b1)
         (i_owner == OWN_HOST): begin
            if (i_host_we) begin
               o_sram_waddr1 = i_host_addr;
               o_sram_wdata1 = i_host_wdata;
               o_sram_we1    = 1'b1;
            end else begin
               o_sram_raddr1 = i_host_addr;
            end
         end
         (i_owner == OWN_FFT): begin
            o_sram_raddr1 = i_fft_raddr1;
            o_sram_raddr2 = i_fft_raddr2;
            o_sram_waddr1 = i_fft_waddr1;
            o_sram_waddr2 = i_fft_waddr2;
            o_sram_wdata1 = i_fft_wdata1;
            o_sram_wdata2 = i_fft_wdata2;
            o_sram_we1    = i_fft_we;
            o_sram_we2    = i_fft_we;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/fft_sram_sched.sv
// Run controller and SRAM port scheduler between host and fft_top.
// Ports: start/abort/config control, host SRAM access, FFT link, SRAM.
module fft_sram_sched
   import fft_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int DRAIN_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [2:0]        i_point_config,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   input  logic              i_host_req,
   input  logic              i_host_we,
   input  logic [ADDR_W-1:0] i_host_addr,
   input  logic [DATA_W-1:0] i_host_wdata,
   output logic              o_host_gnt,
   output logic [DATA_W-1:0] o_host_rdata,
   output logic              o_host_rvalid,
   output logic              o_fft_working,
   output logic [2:0]        o_fft_point_config,
   input  logic              i_fft_done,
   input  logic [ADDR_W-1:0] i_fft_raddr1,
   input  logic [ADDR_W-1:0] i_fft_raddr2,
   input  logic [ADDR_W-1:0] i_fft_waddr1,
   input  logic [ADDR_W-1:0] i_fft_waddr2,
   input  logic [DATA_W-1:0] i_fft_wdata1,
   input  logic [DATA_W-1:0] i_fft_wdata2,
   input  logic              i_fft_we,
   output logic [ADDR_W-1:0] o_sram_raddr1,
   output logic [ADDR_W-1:0] o_sram_raddr2,
   output logic [ADDR_W-1:0] o_sram_waddr1,
   output logic [ADDR_W-1:0] o_sram_waddr2,
   output logic [DATA_W-1:0] o_sram_wdata1,
   output logic [DATA_W-1:0] o_sram_wdata2,
   output logic              o_sram_we1,
   output logic              o_sram_we2,
   input  logic [DATA_W-1:0] i_sram_rdata1
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

   sched_state_t    state;
   logic [WD_W-1:0] wd_cnt;
   logic [DC_W-1:0] drain_cnt;
   logic [1:0]      owner;
   logic            fft_owns;

   assign fft_owns   = (state == RUN) || (state == DRAIN);
   // Start beats a same-cycle host request; the host simply retries.
   assign o_host_gnt = i_host_req && (state == IDLE) && !i_start;

   // Abort cuts the FFT off the SRAM in the very cycle it is raised.
   always_comb begin
      owner = OWN_NONE;
      if (o_host_gnt) begin
         owner = OWN_HOST;
      end else if (fft_owns && !i_abort) begin
         owner = OWN_FFT;
      end
   end

   sram_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mux (
      .i_owner       (owner),
      .i_host_we     (i_host_we),
      .i_host_addr   (i_host_addr),
      .i_host_wdata  (i_host_wdata),
      .i_fft_raddr1  (i_fft_raddr1),
      .i_fft_raddr2  (i_fft_raddr2),
      .i_fft_waddr1  (i_fft_waddr1),
      .i_fft_waddr2  (i_fft_waddr2),
      .i_fft_wdata1  (i_fft_wdata1),
      .i_fft_wdata2  (i_fft_wdata2),
      .i_fft_we      (i_fft_we),
      .o_sram_raddr1 (o_sram_raddr1),
      .o_sram_raddr2 (o_sram_raddr2),
      .o_sram_waddr1 (o_sram_waddr1),
      .o_sram_waddr2 (o_sram_waddr2),
      .o_sram_wdata1 (o_sram_wdata1),
      .o_sram_wdata2 (o_sram_wdata2),
      .o_sram_we1    (o_sram_we1),
      .o_sram_we2    (o_sram_we2)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state              <= IDLE;
         wd_cnt             <= '0;
         drain_cnt          <= '0;
         o_busy             <= 1'b0;
         o_done             <= 1'b0;
         o_err              <= 1'b0;
         o_fft_working      <= 1'b0;
         o_fft_point_config <= '0;
         o_host_rdata       <= '0;
         o_host_rvalid      <= 1'b0;
      end else begin
         o_done        <= 1'b0;
         o_err         <= 1'b0;
         o_host_rvalid <= o_host_gnt && !i_host_we;
         if (o_host_gnt && !i_host_we) begin
            o_host_rdata <= i_sram_rdata1;
         end
         unique case (state)
            IDLE: begin
               if (i_start) begin
                  if (i_point_config <= 3'(MAX_POINT_CFG)) begin
                     o_fft_point_config <= i_point_config;
                     state              <= RUN;
                     o_fft_working      <= 1'b1;
                     o_busy             <= 1'b1;
                     wd_cnt             <= '0;
                  end else begin
                     o_err <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (i_abort) begin
                  state         <= IDLE;
                  o_fft_working <= 1'b0;
                  o_busy        <= 1'b0;
                  o_err         <= 1'b1;
               end else if (i_fft_done) begin
                  state         <= DRAIN;
                  o_fft_working <= 1'b0;
                  drain_cnt     <= '0;
               end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  state         <= IDLE;
                  o_fft_working <= 1'b0;
                  o_busy        <= 1'b0;
                  o_err         <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (i_abort) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
                  o_err  <= 1'b1;
               end else if (drain_cnt == DC_W'(DRAIN_CYCLES - 1)) begin
                  state  <= DONE;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_sram_sched.sv
// Directed bench for fft_sram_sched with a behavioural SRAM model.
// A second instance with a short watchdog covers the timeout path.
module tb_fft_sram_sched;

   logic         clk = 1'b0;
   logic         rstn;
   logic         start, abort, host_req, host_we, fft_done, fft_we;
   logic [2:0]   cfg;
   logic [7:0]   host_addr;
   logic [127:0] host_wdata;
   logic [7:0]   fft_raddr1, fft_raddr2, fft_waddr1, fft_waddr2;
   logic [127:0] fft_wdata1, fft_wdata2;

   logic         busy, done, err, host_gnt, host_rvalid, working;
   logic [127:0] host_rdata, sram_wdata1, sram_wdata2, sram_rdata1;
   logic [2:0]   pcfg;
   logic [7:0]   sram_raddr1, sram_raddr2, sram_waddr1, sram_waddr2;
   logic         sram_we1, sram_we2;

   logic         w_busy, w_done, w_err, w_gnt, w_rvalid, w_working;
   logic [127:0] w_rdata, w_wdata1, w_wdata2;
   logic [2:0]   w_pcfg;
   logic [7:0]   w_raddr1, w_raddr2, w_waddr1, w_waddr2;
   logic         w_we1, w_we2;

   logic [127:0] mem [256];

   int pass = 0;
   int total = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_we1) mem[sram_waddr1] <= sram_wdata1;
      if (sram_we2) mem[sram_waddr2] <= sram_wdata2;
   end
   assign sram_rdata1 = mem[sram_raddr1];

   fft_sram_sched u_dut (
      .clk(clk), .rstn(rstn), .i_start(start), .i_abort(abort),
      .i_point_config(cfg), .o_busy(busy), .o_done(done), .o_err(err),
      .i_host_req(host_req), .i_host_we(host_we),
      .i_host_addr(host_addr), .i_host_wdata(host_wdata),
      .o_host_gnt(host_gnt), .o_host_rdata(host_rdata),
      .o_host_rvalid(host_rvalid), .o_fft_working(working),
      .o_fft_point_config(pcfg), .i_fft_done(fft_done),
      .i_fft_raddr1(fft_raddr1), .i_fft_raddr2(fft_raddr2),
      .i_fft_waddr1(fft_waddr1), .i_fft_waddr2(fft_waddr2),
      .i_fft_wdata1(fft_wdata1), .i_fft_wdata2(fft_wdata2),
      .i_fft_we(fft_we),
      .o_sram_raddr1(sram_raddr1), .o_sram_raddr2(sram_raddr2),
      .o_sram_waddr1(sram_waddr1), .o_sram_waddr2(sram_waddr2),
      .o_sram_wdata1(sram_wdata1), .o_sram_wdata2(sram_wdata2),
      .o_sram_we1(sram_we1), .o_sram_we2(sram_we2),
      .i_sram_rdata1(sram_rdata1)
   );

   fft_sram_sched #(.TIMEOUT_CYCLES(16)) u_wd (
      .clk(clk), .rstn(rstn), .i_start(start), .i_abort(abort),
      .i_point_config(cfg), .o_busy(w_busy), .o_done(w_done), .o_err(w_err),
      .i_host_req(host_req), .i_host_we(host_we),
      .i_host_addr(host_addr), .i_host_wdata(host_wdata),
      .o_host_gnt(w_gnt), .o_host_rdata(w_rdata),
      .o_host_rvalid(w_rvalid), .o_fft_working(w_working),
      .o_fft_point_config(w_pcfg), .i_fft_done(fft_done),
      .i_fft_raddr1(fft_raddr1), .i_fft_raddr2(fft_raddr2),
      .i_fft_waddr1(fft_waddr1), .i_fft_waddr2(fft_waddr2),
      .i_fft_wdata1(fft_wdata1), .i_fft_wdata2(fft_wdata2),
      .i_fft_we(fft_we),
      .o_sram_raddr1(w_raddr1), .o_sram_raddr2(w_raddr2),
      .o_sram_waddr1(w_waddr1), .o_sram_waddr2(w_waddr2),
      .o_sram_wdata1(w_wdata1), .o_sram_wdata2(w_wdata2),
      .o_sram_we1(w_we1), .o_sram_we2(w_we2),
      .i_sram_rdata1('0)
   );

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   typedef struct {
      logic         req;
      logic         we;
      logic [7:0]   addr;
      logic [127:0] wdata;
      logic         gnt;
      logic         we1;
      logic         rvalid;
      logic [127:0] rdata;
   } vec_t;

   vec_t vt [6];

   initial begin
      int bad, bad_g, bad_w, bad_e, bad_k;
      int dn_cnt, dn_at, bz_cnt, wk_cnt, got;
      logic [7:0] a8;

      vt[0] = '{1'b1, 1'b0, 8'h2A, 128'h0, 1'b1, 1'b0, 1'b1, 128'h2A};
      vt[1] = '{1'b1, 1'b0, 8'h00, 128'h0, 1'b1, 1'b0, 1'b1, 128'h0};
      vt[2] = '{1'b1, 1'b0, 8'hFF, 128'h0, 1'b1, 1'b0, 1'b1, 128'hFF};
      vt[3] = '{1'b1, 1'b1, 8'h10, 128'hABCD, 1'b1, 1'b1, 1'b0, 128'hFF};
      vt[4] = '{1'b1, 1'b0, 8'h10, 128'h0, 1'b1, 1'b0, 1'b1, 128'hABCD};
      vt[5] = '{1'b0, 1'b0, 8'h2A, 128'h0, 1'b0, 1'b0, 1'b0, 128'hABCD};

      rstn = 1'b0; start = 1'b0; abort = 1'b0; cfg = 3'd0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      fft_done = 1'b0; fft_we = 1'b0;
      fft_raddr1 = '0; fft_raddr2 = '0; fft_waddr1 = 8'hC0; fft_waddr2 = '0;
      fft_wdata1 = '0; fft_wdata2 = '0;

      #12;
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_outs", 128'({done, err, host_gnt, host_rvalid, working,
                            sram_we1, sram_we2}), 128'(0));
      chk("rst_cfg", 128'(pcfg), 128'(0));
      chk("rst_rdata", host_rdata, 128'(0));
      chk("rst_addr", 128'({sram_waddr1, sram_raddr1}), 128'(0));
      @(negedge clk) rstn = 1'b1;

      bad = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         host_req = 1'b1; host_we = 1'b1;
         host_addr = 8'(i); host_wdata = 128'(i);
         #1;
         if (!(host_gnt && sram_we1 && !sram_we2 &&
               sram_waddr1 == 8'(i) && sram_wdata1 == 128'(i))) bad++;
      end
      chk("host_write_fill", 128'(bad), 128'(0));

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         host_req = vt[i].req; host_we = vt[i].we;
         host_addr = vt[i].addr; host_wdata = vt[i].wdata;
         #1;
         chk($sformatf("vec%0d_gnt", i), 128'(host_gnt), 128'(vt[i].gnt));
         chk($sformatf("vec%0d_we1", i), 128'(sram_we1), 128'(vt[i].we1));
         @(posedge clk); #1;
         chk($sformatf("vec%0d_rvalid", i), 128'(host_rvalid),
             128'(vt[i].rvalid));
         chk($sformatf("vec%0d_rdata", i), host_rdata, vt[i].rdata);
      end

      @(negedge clk);
      host_req = 1'b0; start = 1'b1; cfg = 3'd3;
      @(posedge clk); #1;
      chk("run_working_rise", 128'(working), 128'(1));
      chk("run_cfg_latch", 128'(pcfg), 128'(3));
      host_we = 1'b0; host_addr = 8'h2A;
      bad_g = 0; bad_w = 0; bad_e = 0; bad_k = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         host_req = 1'b1;
         a8 = 8'(k);
         fft_we = a8[0];
         fft_waddr2 = 8'h80 + a8;
         fft_wdata2 = 128'(k + 1000);
         start = (k == 50);
         cfg = (k == 50) ? 3'd5 : 3'd3;
         fft_done = (k == 99);
         #1;
         if (host_gnt || host_rvalid) bad_g++;
         if (sram_we1 !== fft_we || sram_we2 !== fft_we ||
             sram_waddr2 !== fft_waddr2 ||
             sram_wdata2 !== fft_wdata2) bad_w++;
         if (err) bad_e++;
         if (!working || !busy) bad_k++;
      end
      chk("run_host_blocked", 128'(bad_g), 128'(0));
      chk("run_fft_pass", 128'(bad_w), 128'(0));
      chk("run_no_err", 128'(bad_e), 128'(0));
      chk("run_working", 128'(bad_k), 128'(0));
      chk("run_cfg_kept", 128'(pcfg), 128'(3));

      dn_cnt = 0; dn_at = -1; bz_cnt = 0; wk_cnt = 0; bad = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         start = 1'b0; fft_done = 1'b0; fft_we = 1'b1;
         #1;
         if (done) begin dn_cnt++; dn_at = j; end
         if (busy) bz_cnt++;
         if (working) wk_cnt++;
         if (busy && (!sram_we1 || !sram_we2 || host_gnt)) bad++;
         if (j == 5) chk("gnt_after_done", 128'(host_gnt), 128'(1));
      end
      chk("drain_cycles", 128'(bz_cnt), 128'(4));
      chk("done_pulses", 128'(dn_cnt), 128'(1));
      chk("done_at", 128'(dn_at), 128'(4));
      chk("drain_working", 128'(wk_cnt), 128'(0));
      chk("drain_fft_pass", 128'(bad), 128'(0));

      @(negedge clk);
      host_req = 1'b0; fft_we = 1'b0; fft_done = 1'b1;
      @(negedge clk) fft_done = 1'b0;
      #1;
      chk("stray_done_idle", 128'({busy, working, done}), 128'(0));

      @(negedge clk);
      start = 1'b1; cfg = 3'd5;
      @(posedge clk); #1;
      chk("badcfg_err", 128'(err), 128'(1));
      chk("badcfg_idle", 128'({busy, working, sram_we1, sram_we2}),
          128'(0));
      @(negedge clk) start = 1'b0;
      @(posedge clk); #1;
      chk("badcfg_err_pulse", 128'(err), 128'(0));

      @(negedge clk);
      start = 1'b1; cfg = 3'd2;
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h05;
      #1;
      chk("start_beats_host", 128'(host_gnt), 128'(0));
      chk("start_no_we", 128'(sram_we1), 128'(0));
      @(posedge clk); #1;
      chk("start2_busy", 128'(busy), 128'(1));
      chk("start2_cfg", 128'(pcfg), 128'(2));
      @(negedge clk);
      start = 1'b0; host_req = 1'b0; fft_done = 1'b1; fft_we = 1'b1;
      @(negedge clk);
      fft_done = 1'b0; abort = 1'b1;
      #1;
      chk("abort_in_drain_state", 128'({busy, working}), 128'(2));
      chk("abort_we_forced", 128'({sram_we1, sram_we2}), 128'(0));
      @(posedge clk); #1;
      chk("abort_err", 128'(err), 128'(1));
      chk("abort_idle", 128'(busy), 128'(0));
      @(negedge clk) abort = 1'b0;
      dn_cnt = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk); #1;
         if (done) dn_cnt++;
      end
      chk("abort_no_done", 128'(dn_cnt), 128'(0));

      @(negedge clk);
      start = 1'b1; cfg = 3'd1; fft_we = 1'b0;
      @(negedge clk) start = 1'b0;
      wk_cnt = 0; got = 0;
      for (int j = 0; j < 40 && got == 0; j++) begin
         #1;
         if (w_err) got = 1;
         else if (w_working) wk_cnt++;
         @(negedge clk);
      end
      chk("timeout_err", 128'(got), 128'(1));
      chk("timeout_run_cycles", 128'(wk_cnt), 128'(16));
      chk("timeout_idle", 128'({w_busy, w_working}), 128'(0));

      #1;
      chk("pre_reset_working", 128'({busy, working}), 128'(3));
      #1 rstn = 1'b0;
      #1;
      chk("reset_mid_run", 128'({busy, working}), 128'(0));
      chk("reset_cfg", 128'(pcfg), 128'(0));
      @(negedge clk);
      rstn = 1'b1;
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h2A;
      #1;
      chk("post_reset_gnt", 128'(host_gnt), 128'(1));
      @(posedge clk); #1;
      chk("post_reset_rvalid", 128'(host_rvalid), 128'(1));
      chk("post_reset_rdata", host_rdata, 128'h2A);
      @(negedge clk) host_req = 1'b0;

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule

// File: doc/fft_sram_sched.md
Name: fft_sram_sched

Overview:
- Run-level controller and SRAM port scheduler that sits between the host/loader and fft_top.
- Owns the dual-port sample SRAM. The host gets the SRAM only while the FFT is idle. The FFT engine gets it exclusively from start until its write pipeline has drained.
- Sequences one transform per start: validates the config, drives i_working, watches o_fft_done, drains the datapath, and reports done or error.

Parameters:
- ADDR_W, 8, SRAM address width.
- DATA_W, 128, SRAM word width (4 complex samples).
- DRAIN_CYCLES, 4, cycles held after fft done so the datapath's last writes land.
- TIMEOUT_CYCLES, 4096, watchdog limit on cycles spent in RUN.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse; begin a transform
- i_abort  in  1  level; kill the run in progress
- i_point_config  in  3  requested size; values 0..4 are valid
- o_busy  out  1  high in RUN or DRAIN
- o_done  out  1  one-cycle pulse on successful completion
- o_err  out  1  one-cycle pulse on bad config, timeout or abort
- i_host_req  in  1  host access request; held until granted
- i_host_we  in  1  1 = write, 0 = read
- i_host_addr  in  ADDR_W  host address
- i_host_wdata  in  DATA_W  host write data
- o_host_gnt  out  1  combinational grant, same cycle as the request
- o_host_rdata  out  DATA_W  read data
- o_host_rvalid  out  1  read data valid
- o_fft_working  out  1  to fft_top i_working
- o_fft_point_config  out  3  latched config, to fft_top
- i_fft_done  in  1  from fft_top o_fft_done
- i_fft_raddr1, i_fft_raddr2, i_fft_waddr1, i_fft_waddr2  in  ADDR_W  FFT addresses
- i_fft_wdata1, i_fft_wdata2  in  DATA_W  FFT write data
- i_fft_we  in  1  FFT global write enable
- o_sram_raddr1, o_sram_raddr2, o_sram_waddr1, o_sram_waddr2  out  ADDR_W  to SRAM
- o_sram_wdata1, o_sram_wdata2  out  DATA_W  to SRAM
- o_sram_we1, o_sram_we2  out  1  per-port write enables
- i_sram_rdata1  in  DATA_W  SRAM port-1 read data

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including o_fft_point_config and o_host_rdata.
  - Counters 0.
- States and transitions:
  - IDLE, i_start with config <= 4: latch config, enter RUN. o_fft_working rises on the following cycle.
  - IDLE, i_start with config > 4: o_err pulse next cycle, stay IDLE.
  - RUN: o_fft_working = 1 and the watchdog increments each cycle.
    - i_fft_done seen: enter DRAIN and drop o_fft_working.
    - Watchdog reaches TIMEOUT_CYCLES-1: enter IDLE, o_err pulse.
  - DRAIN: count DRAIN_CYCLES, then enter DONE.
  - DONE: o_done pulse for 1 cycle, then IDLE.
- i_abort in RUN or DRAIN:
  - Next cycle state is IDLE, o_fft_working = 0, o_err pulses.
  - SRAM enables are forced to 0 from that cycle on.
  - i_abort is ignored in IDLE.
- Host arbitration:
  - o_host_gnt = i_host_req when state == IDLE and i_start == 0. On a simultaneous request and start, the start wins and the host retries.
  - Granted write: o_sram_waddr1 = i_host_addr, o_sram_wdata1 = i_host_wdata, o_sram_we1 = 1, o_sram_we2 = 0.
  - Granted read: o_sram_raddr1 = i_host_addr. o_host_rvalid and o_host_rdata (registered from i_sram_rdata1) appear 1 cycle later, so read latency is 1.
  - A read may be granted back-to-back every cycle.
- FFT ownership (RUN and DRAIN):
  - SRAM address and data outputs pass through the i_fft_* inputs combinationally.
  - o_sram_we1 = o_sram_we2 = i_fft_we.
  - Host is never granted.
- When neither host nor FFT owns the SRAM, both write enables are 0 and addresses are held at 0.
- A second i_start while busy is ignored: no error, and the latched config is unchanged.
- i_fft_done outside RUN is ignored.
- Reset mid-run: all state clears immediately (asynchronous), and o_fft_working drops with it.
- Watchdog width is clog2(TIMEOUT_CYCLES). It clears on entering RUN.

Decomposition:
- fft_pkg holds:
  - a state enum, sched_state_t {IDLE, RUN, DRAIN, DONE};
  - MAX_POINT_CFG = 4;
  - ADDR_W and DATA_W defaults.
- One sub-module, sram_port_mux: purely combinational selection between host and FFT for all SRAM address, data and write-enable outputs, driven by an owner select.
- The FSM, watchdog and drain counter stay in fft_sram_sched.

Test Plan:
- Host writes words 0..255 with data = address, then reads address 0x2A → grant in the same cycle, rvalid 1 cycle later, rdata = 0x2A.
- i_start with config 3, fft_done asserted 100 cycles later → o_fft_working high for exactly the RUN window, then DRAIN_CYCLES = 4 cycles, then o_done one pulse, o_busy low.
- i_host_req during RUN → o_host_gnt stays 0 and fft writes pass through with we1 = we2 = i_fft_we. After o_done the next host request is granted.
- i_start with config 5 → o_err pulse, o_busy stays 0, no SRAM enables. Separately, start and host request in the same IDLE cycle → start wins and o_host_gnt = 0.
- Timeout with TIMEOUT_CYCLES = 16 and no fft_done → o_err after 16 RUN cycles, back to IDLE. Separately, i_abort in DRAIN → o_err pulse and o_done never asserts.
- rstn pulled low mid-RUN → o_fft_working and o_busy go to 0 immediately. After release, a host read is granted.
